// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one ram1024x32 between NUM_REQ requesters.
// Round-robin grant that is held until the owner releases it or drops its
// request. A watchdog revokes over-long grants, and one dead GAP cycle
// separates consecutive owners.
//
// Ports:
//   clock_i, reset_i    system clock, asynchronous active-high reset
//   req_i               per-requester request, level-held for the transaction
//   release_i           per-requester end-of-transaction pulse
//   req_address_i       flattened 10-bit addresses, requester i at [10i+9:10i]
//   req_data_i          flattened 32-bit write data, requester i at [32i+31:32i]
//   req_wren_i          per-requester write enable
//   grant_o             registered grant, one-hot or zero
//   busy_o              high while any grant is held
//   timeout_flag_o      one-cycle pulse in the GAP after a watchdog revocation
//   ram_address_o, ram_data_o, ram_wren_o   owner's bundle, zero when ungranted
//   ram_clock_o         copy of clock_i
module ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned HOLD_LIMIT = 1024,
  parameter int unsigned CNT_W      = 11
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    release_i,
  input  logic [NUM_REQ*10-1:0] req_address_i,
  input  logic [NUM_REQ*32-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]    req_wren_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  busy_o,
  output logic                  timeout_flag_o,
  output logic [9:0]            ram_address_o,
  output logic                  ram_clock_o,
  output logic [31:0]           ram_data_o,
  output logic                  ram_wren_o
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic                 timeout_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     owner_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 own_release;
  logic                 own_req;
  logic                 wd_hit;
  logic                 exit_hit;
  logic [IDX_W-1:0]     ptr_after_owner;

  // Round-robin search: first set request starting at the pointer, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_onehot = NUM_REQ'(1) << pick_idx;

  // Owner exit conditions; the watchdog compare is disabled when HOLD_LIMIT is 0.
  assign own_release     = release_i[owner_q];
  assign own_req         = req_i[owner_q];
  assign wd_hit          = (HOLD_LIMIT != 0) && (cnt_q == CNT_W'(HOLD_LIMIT - 1));
  assign exit_hit        = own_release || !own_req || wd_hit;
  assign ptr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  // Arbiter FSM with registered grant, busy and timeout flag.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (pick_found) begin
            state_q <= GRANTED;
            grant_q <= pick_onehot;
            busy_q  <= 1'b1;
            owner_q <= pick_idx;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        GRANTED: begin
          if (exit_hit) begin
            state_q   <= GAP;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_after_owner;
            // Flag only revocations caused purely by the watchdog.
            timeout_q <= wd_hit && !own_release && own_req;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // RAM bundle follows the registered grant, so it is zero in IDLE/GAP and
  // clears immediately on reset.
  always_comb begin
    ram_address_o = '0;
    ram_data_o    = '0;
    ram_wren_o    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        ram_address_o = req_address_i[i*ADDR_W +: ADDR_W];
        ram_data_o    = req_data_i[i*DATA_W +: DATA_W];
        ram_wren_o    = req_wren_i[i];
      end
    end
  end

  assign grant_o        = grant_q;
  assign busy_o         = busy_q;
  assign timeout_flag_o = timeout_q;
  assign ram_clock_o    = clock_i;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single ram1024x32 instance between the card-list operation modules: allocate_memory, add_card, remove_nth_card and split_list.
- Each requester drives its own address, data and write-enable bundle. The arbiter grants exactly one requester at a time, round-robin, and holds the grant until that requester releases it.
- A watchdog revokes grants held too long.
- ram_q fans out directly to all requesters and does not pass through this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_LIMIT, 1024, maximum consecutive granted cycles before forced revocation; 0 disables the watchdog.
- CNT_W, 11, width of the hold counter; must satisfy 2^CNT_W > HOLD_LIMIT.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request, level-held for the whole transaction
- release  in  NUM_REQ  per-requester end-of-transaction pulse
- req_address  in  NUM_REQ*10  flattened addresses; requester i uses bits [10i+9:10i]
- req_data  in  NUM_REQ*32  flattened write data; requester i uses bits [32i+31:32i]
- req_wren  in  NUM_REQ  per-requester write enable
- grant  out  NUM_REQ  one-hot or zero; registered
- busy  out  1  high while any grant is held
- timeout_flag  out  1  one-cycle pulse on forced revocation
- ram_address  out  10  to ram1024x32 address
- ram_clock  out  1  equals clock
- ram_data  out  32  to ram1024x32 data
- ram_wren  out  1  to ram1024x32 wren

Behaviour:
- Reset (async, active-high):
  - state=IDLE, grant=0, busy=0, timeout_flag=0.
  - Priority pointer=0, so requester 0 is favoured first. Hold counter=0.
  - Reset takes effect immediately, even mid-transaction. ram_wren drops to 0 combinationally because grant=0.
- States: IDLE, GRANTED, GAP.
- IDLE:
  - With req==0, stay in IDLE.
  - Otherwise, at the clock edge, grant the first set req bit searching from pointer upward with wrap-around. Enter GRANTED and clear the counter.
  - Latency: req sampled high at edge t gives grant high after edge t, i.e. 1 cycle.
- GRANTED (winner g):
  - ram_address, ram_data and ram_wren are combinationally muxed from requester g's bundle.
  - The counter increments each cycle.
  - Exit to GAP at the edge where any of these holds:
    - release[g]=1
    - req[g]=0
    - HOLD_LIMIT!=0 and counter==HOLD_LIMIT-1
  - On exit: grant cleared, pointer set to (g+1) mod NUM_REQ.
  - If the exit is caused only by the watchdog, timeout_flag pulses for exactly the GAP cycle.
- GAP:
  - One dead cycle with grant=0 and ram_wren=0. This guarantees no write from the old owner overlaps the new owner.
  - Arbitration is identical to IDLE: a pending req is granted at the GAP edge, otherwise go to IDLE.
- Ungranted outputs: ram_address=0, ram_data=0, ram_wren=0.
- Ignored inputs:
  - release bits of non-granted requesters are ignored.
  - release in IDLE or GAP is ignored.
  - req_wren from non-granted requesters never reaches the RAM.
- Simultaneous release[g] and a new req from g: g releases. g is re-granted only if no other requester is pending, because the pointer has already moved past g.
- Fairness: with all NUM_REQ requesters continuously requesting, the grant order is strictly 0,1,2,...,NUM_REQ-1,0...
- The watchdog-revoked requester is not blacklisted. It competes normally after GAP at lowest priority.
- busy = |grant.

Test Plan:
- Reset, then req=4'b0100 at cycle 2 -> grant=4'b0100 after the next edge. ram_address equals req_address[29:20]. After release[2] pulses, grant=0 for exactly one cycle (GAP), then IDLE.
- req=4'b1111 held, each owner pulses release one cycle after being granted -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001. No two grant bits are ever high together.
- HOLD_LIMIT=8, requester 1 holds req high with no release -> grant[1] high for exactly 8 cycles, then timeout_flag=1 for 1 cycle with grant=0. If requester 3 is pending, grant=1000 next.
- Requester 0 granted with req_wren[0]=1 and address 10'h3FF; requester 2 asserts req_wren[2]=1 with address 10'h010 -> ram_wren reflects only requester 0. ram_address=10'h3FF, never 10'h010.
- Assert reset mid-GRANTED while ram_wren=1 -> ram_wren, grant, busy go to 0 asynchronously, before the next edge. After reset deasserts with req=4'b0110, requester 1 is granted first.
- Requester 0 drops req without pulsing release -> treated as a release: GAP, pointer=1, timeout_flag stays 0.
